// File: rtl/lii_out_packer.sv
// Packs L = PW/DW consecutive kernel stream beats into one LII flit and queues
// flits in a small FIFO toward LII output channel 0; ce stalls the kernel when full.
module lii_out_packer #(
  parameter int           PW     = 128,
  parameter int           DW     = 64,
  parameter logic [7:0]   SRC_ID = 8'h00,
  parameter logic [7:0]   DST_ID = 8'h01,
  parameter int           DEPTH  = 4
) (
  input  logic               aclk,
  input  logic               arstn,
  input  logic [DW-1:0]      input_stream_tdata,
  input  logic               input_stream_tvalid,
  input  logic               input_stream_tlast,
  output logic               input_stream_tready,
  output logic [PW-1:0]      lii_out_p0_tdata,
  output logic [PW/DW-1:0]   lii_out_p0_tkeep,
  output logic               lii_out_p0_tlast,
  output logic               lii_out_p0_tvalid,
  input  logic               lii_out_p0_tready,
  output logic [7:0]         lii_out_p0_src,
  output logic [7:0]         lii_out_p0_dst,
  output logic               ce
);

  localparam int L    = PW / DW;
  localparam int LW   = (L > 1) ? $clog2(L) : 1;
  localparam int PTRW = $clog2(DEPTH);
  localparam int CW   = $clog2(DEPTH + 1);
  localparam logic [LW-1:0] LAST_LANE = LW'(L - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and ready never depends on valid.
  logic [LW-1:0]   lane;
  logic [PW-1:0]   acc;
  logic [L-1:0]    keep;
  logic            rst_done;
  logic [CW-1:0]   count;
  logic [PTRW-1:0] wr_ptr;
  logic [PTRW-1:0] rd_ptr;

  logic [PW-1:0]   mem_data [DEPTH];
  logic [L-1:0]    mem_keep [DEPTH];
  logic            mem_last [DEPTH];

  logic            beat_fire;
  logic            flit_fire;
  logic            flit_done;
  logic [PW-1:0]   push_data;
  logic [L-1:0]    push_keep;

  assign input_stream_tready = rst_done & (count != FULL_CNT);
  assign ce                  = input_stream_tready;
  assign lii_out_p0_tvalid   = (count != '0);
  assign lii_out_p0_tdata    = mem_data[rd_ptr];
  assign lii_out_p0_tkeep    = mem_keep[rd_ptr];
  assign lii_out_p0_tlast    = mem_last[rd_ptr];
  assign lii_out_p0_src      = SRC_ID;
  assign lii_out_p0_dst      = DST_ID;

  assign beat_fire = input_stream_tvalid & input_stream_tready;
  assign flit_fire = lii_out_p0_tvalid & lii_out_p0_tready;
  assign flit_done = beat_fire & ((lane == LAST_LANE) | input_stream_tlast);

  // Accumulator as it would look with the current beat merged into its lane.
  always_comb begin
    push_data = acc;
    push_keep = keep;
    for (int i = 0; i < L; i++) begin
      if (lane == LW'(i)) begin
        push_data[i*DW +: DW] = input_stream_tdata;
        push_keep[i]          = 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      rst_done <= 1'b0;
    end else begin
      rst_done <= 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      lane <= '0;
      acc  <= '0;
      keep <= '0;
    end else if (flit_done) begin
      lane <= '0;
      acc  <= '0;
      keep <= '0;
    end else if (beat_fire) begin
      lane <= lane + LW'(1);
      acc  <= push_data;
      keep <= push_keep;
    end
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (flit_done) wr_ptr <= wr_ptr + PTRW'(1);
      if (flit_fire) rd_ptr <= rd_ptr + PTRW'(1);
      case ({flit_done, flit_fire})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible once count covers them.
  always_ff @(posedge aclk) begin
    if (flit_done) begin
      mem_data[wr_ptr] <= push_data;
      mem_keep[wr_ptr] <= push_keep;
      mem_last[wr_ptr] <= input_stream_tlast;
    end
  end

endmodule

// File: doc/lii_out_packer.md
# lii_out_packer

Kernel-to-LII output packer: the transmit-side counterpart of the top-level input unpack wrapper. It accepts a DW-bit AXI-Stream from an HLS kernel and packs PW/DW consecutive beats into one PW-bit LII phy flit. Each flit is tagged with fixed src/dst IDs and queued in a small FIFO toward LII output channel 0. It also drives the kernel clock enable from its own buffer space, so the kernel stalls instead of losing data.

## Interface
- PW, 128, LII packing width (flit width)
- DW, 64, kernel stream data width; PW must be an integer multiple of DW; L = PW/DW lanes
- SRC_ID, 8'h00, constant driven on lii_out_p0_src
- DST_ID, 8'h01, constant driven on lii_out_p0_dst
- DEPTH, 4, flit FIFO depth; power of two, >= 2
- aclk  in  1  single clock; all logic rising-edge
- arstn  in  1  asynchronous, active-low reset
- input_stream_tdata  in  DW  kernel data beat
- input_stream_tvalid  in  1  kernel beat valid
- input_stream_tlast  in  1  end of kernel packet; flushes a partial flit
- input_stream_tready  out  1  wrapper can accept a beat
- lii_out_p0_tdata  out  PW  packed flit
- lii_out_p0_tkeep  out  L  per-lane valid mask; bit i covers tdata[DW*i +: DW]
- lii_out_p0_tlast  out  1  flit ends a kernel packet
- lii_out_p0_tvalid  out  1  flit valid
- lii_out_p0_tready  in  1  phy sink ready
- lii_out_p0_src  out  8  SRC_ID, constant
- lii_out_p0_dst  out  8  DST_ID, constant
- ce  out  1  kernel clock enable

## Operation
- A beat transfers when input_stream_tvalid & input_stream_tready. A flit transfers when lii_out_p0_tvalid & lii_out_p0_tready.
- Lane counter: 0..L-1. An accepted beat is written into accumulator lane[lane] and sets keep bit lane.
- Flit completion: the accepted beat has lane == L-1 or tlast = 1. On completion:
  - push {accumulator including this beat, keep, tlast} into the FIFO;
  - clear lane, accumulator and keep to 0 on the same edge.
- Unfilled lanes of a partial flit are zero, with keep bits 0.
- When tlast = 1 on lane L-1, one flit is pushed with keep all ones and tlast = 1.
- FIFO occupancy count runs 0..DEPTH with wrap-around read/write pointers.
  - lii_out_p0_tvalid = (count != 0). tdata, tkeep and tlast come from the FIFO head.
  - Head data must hold stable while tvalid = 1 and tready = 0.
- input_stream_tready = rst_done & (count != DEPTH).
  - This applies uniformly, including non-completing lane-0 beats.
  - No same-cycle bypass: a pop does not raise tready in that same cycle.
- ce = input_stream_tready.
- rst_done is a register: cleared by reset, set on the first rising edge after arstn deasserts.
- Simultaneous push and pop: count unchanged, and both pointers advance.
- Pop when empty and push when full cannot occur by construction; no error reporting is needed.

## Timing
- Reset (arstn low, asynchronous) forces the following, all immediately without waiting for a clock edge:
  - lane = 0, accumulator = 0, keep = 0;
  - count = 0, pointers = 0;
  - rst_done = 0, so lii_out_p0_tvalid = 0, input_stream_tready = 0, ce = 0.
- tdata, tkeep and tlast are don't-care while tvalid = 0. src and dst are constant, including during reset.
- First cycle after reset release: input_stream_tready = 0. From the second edge onward, tready is 1 while the FIFO is not full.
- Latency: a completing beat accepted at edge N gives tvalid = 1 with that flit at head from edge N onward, when the FIFO was empty.
- Throughput: one flit every L beats at full kernel rate, with no bubbles while the sink is ready.
- Full FIFO: tready and ce fall on the edge that makes count = DEPTH. They rise again on the edge after the first pop.
- Reset mid-operation: all pending lanes and queued flits are discarded. No partial flit is emitted after release.

## Test plan
- Beats 64'h1111_1111_1111_1111 then 64'h2222_2222_2222_2222 (tlast 0), sink ready -> one flit with:
  - tdata = 128'h2222..._1111..., tkeep = 2'b11, tlast = 0, src = 00, dst = 01;
  - tvalid for exactly one cycle.
- Single beat 64'hA5 with tlast = 1 -> flit with tdata = 128'h0..._00A5, tkeep = 2'b01, tlast = 1; next flit starts at lane 0.
- Sink tready = 0, kernel drives 10 beats (DEPTH = 4):
  - 8 beats accepted, then tready = ce = 0 with count = 4;
  - sink released -> 4 flits in order, data held stable while stalled;
  - tready returns 1 on the edge after the first pop.
- Steady streaming with sink toggling ready every cycle, count held at 2 -> a simultaneous push/pop edge leaves count = 2. The flit order check passes over 100 random beats.
- Reset mid-operation: with lane 1 pending and 2 flits queued, pulse arstn low between edges:
  - tvalid = 0 and tready = 0 immediately;
  - after release, tready = 0 for one cycle;
  - the first flit out contains only post-reset beats.
- Back-to-back packets: tlast on every beat with sink ready -> each beat becomes its own flit with keep = 2'b01 and tlast = 1. There are no idle cycles and no lane carry-over.
